matriz_scan_ctrl: RTL and testbench

//  Scan and timing controller feeding the 7x5 LED matrix driver. Divides the system clock

---
 rtl/matriz_scan_ctrl_if.sv | 32 +++
 rtl/matriz_scan_ctrl.sv | 116 +++++++++++
 tb/tb_matriz_scan_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/matriz_scan_ctrl_if.sv
// rtl/matriz_scan_ctrl_if.sv - Raw flag/enable inputs and scan/flag outputs of the LED matrix scan controller.
interface matriz_scan_ctrl_if;
   logic       Enable;
   logic       Critico_in;
   logic       Baixo_in;
   logic       Medio_in;
   logic       Alto_in;
   logic       Aspersao_in;
   logic       Gotejamento_in;
   logic [2:0] Clock_Linhas;
   logic       img_sel;
   logic       Critico;
   logic       Baixo;
   logic       Medio;
   logic       Alto;
   logic       Aspersao;
   logic       Gotejamento;
   logic       row_tick;
   logic       frame_tick;

   modport master (
      output Enable, Critico_in, Baixo_in, Medio_in, Alto_in, Aspersao_in, Gotejamento_in,
      input  Clock_Linhas, img_sel, Critico, Baixo, Medio, Alto, Aspersao, Gotejamento,
             row_tick, frame_tick
   );

   modport slave (
      input  Enable, Critico_in, Baixo_in, Medio_in, Alto_in, Aspersao_in, Gotejamento_in,
      output Clock_Linhas, img_sel, Critico, Baixo, Medio, Alto, Aspersao, Gotejamento,
             row_tick, frame_tick
   );
endinterface

// File: rtl/matriz_scan_ctrl.sv
// rtl/matriz_scan_ctrl.sv - Row-scan/image-alternation timing and per-frame flag latch for the 7x5 LED matrix.
module matriz_scan_ctrl #(
   parameter int CLK_DIV        = 1000,
   parameter int ROWS           = 7,
   parameter int FRAMES_PER_IMG = 50
) (
   input  logic               Clock,
   input  logic               Reset,
   matriz_scan_ctrl_if.slave  bus
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FW = ($clog2(FRAMES_PER_IMG + 1) > 0) ? $clog2(FRAMES_PER_IMG + 1) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [2:0]    ROW_MAX   = 3'(ROWS - 1);
   localparam logic [FW-1:0] FRAME_MAX = FW'(FRAMES_PER_IMG - 1);

   typedef enum logic {PRIME, RUN} state_t;

   state_t        state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic [2:0]    row, row_next;
   logic [FW-1:0] frame, frame_next;
   logic          img, img_next;
   logic [5:0]    flags, flags_next, flags_san;
   logic          row_tick_q, row_tick_next;
   logic          frame_tick_q, frame_tick_next;

   // flag order: {Critico, Baixo, Medio, Alto, Aspersao, Gotejamento}
   always_comb begin
      flags_san = 6'b0;
      if (bus.Critico_in) begin
         flags_san[5] = 1'b1;
      end else begin
         if (bus.Baixo_in)      flags_san[4] = 1'b1;
         else if (bus.Medio_in) flags_san[3] = 1'b1;
         else if (bus.Alto_in)  flags_san[2] = 1'b1;
         flags_san[1] = bus.Aspersao_in;
         flags_san[0] = bus.Gotejamento_in;
      end
   end

   always_comb begin
      state_next      = state;
      presc_next      = presc;
      row_next        = row;
      frame_next      = frame;
      img_next        = img;
      flags_next      = flags;
      row_tick_next   = 1'b0;
      frame_tick_next = 1'b0;
      case (state)
         PRIME: begin
            flags_next = flags_san;
            state_next = RUN;
         end
         RUN: begin
            if (bus.Enable) begin
               if (presc == PRESC_MAX) begin
                  presc_next    = '0;
                  row_tick_next = 1'b1;
                  if (row == ROW_MAX) begin
                     // frame boundary: new flags become visible together with row 0
                     row_next        = 3'd0;
                     frame_tick_next = 1'b1;
                     flags_next      = flags_san;
                     if (frame == FRAME_MAX) begin
                        frame_next = '0;
                        img_next   = ~img;
                     end else begin
                        frame_next = frame + FW'(1);
                     end
                  end else begin
                     row_next = row + 3'd1;
                  end
               end else begin
                  presc_next = presc + PW'(1);
               end
            end
         end
         default: state_next = PRIME;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= PRIME;
         presc        <= '0;
         row          <= 3'd0;
         frame        <= '0;
         img          <= 1'b0;
         flags        <= 6'b0;
         row_tick_q   <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state        <= state_next;
         presc        <= presc_next;
         row          <= row_next;
         frame        <= frame_next;
         img          <= img_next;
         flags        <= flags_next;
         row_tick_q   <= row_tick_next;
         frame_tick_q <= frame_tick_next;
      end
   end

   assign bus.Clock_Linhas = row;
   assign bus.img_sel      = img;
   assign bus.Critico      = flags[5];
   assign bus.Baixo        = flags[4];
   assign bus.Medio        = flags[3];
   assign bus.Alto         = flags[2];
   assign bus.Aspersao     = flags[1];
   assign bus.Gotejamento  = flags[0];
   assign bus.row_tick     = row_tick_q;
   assign bus.frame_tick   = frame_tick_q;
endmodule

// File: tb/tb_matriz_scan_ctrl.sv
// tb/tb_matriz_scan_ctrl.sv - Scoreboard bench for matriz_scan_ctrl against a time-count reference model.
module tb_matriz_scan_ctrl;
   localparam int CD   = 4;
   localparam int ROWS = 7;
   localparam int FPI  = 2;

   typedef struct packed {
      logic [2:0] row;
      logic       img;
      logic [5:0] flags;
      logic       rt;
      logic       ft;
   } exp_t;

   logic clk;
   logic rst;
   matriz_scan_ctrl_if bus();

   matriz_scan_ctrl #(.CLK_DIV(CD), .ROWS(ROWS), .FRAMES_PER_IMG(FPI)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;

   // reference: elapsed enabled RUN cycles since PRIME determine every timing output
   int         t = 0;
   bit         prime = 1'b1;
   logic [5:0] mflags = 6'b0;
   bit         mrt = 1'b0;
   bit         mft = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] san(input logic c, b, m, a, s, g);
      int lvl;
      logic [5:0] r;
      lvl = c ? 0 : b ? 1 : m ? 2 : a ? 3 : 4;
      r = (lvl < 4) ? (6'b100000 >> lvl) : 6'b0;
      if (lvl != 0) r[1:0] = {s, g};
      return r;
   endfunction

   function automatic int mrow();
      return (t / CD) % ROWS;
   endfunction

   function automatic int mimg();
      return ((t / (CD * ROWS)) / FPI) % 2;
   endfunction

   task automatic model_edge();
      exp_t e;
      logic [5:0] raw;
      raw = san(bus.Critico_in, bus.Baixo_in, bus.Medio_in, bus.Alto_in,
                bus.Aspersao_in, bus.Gotejamento_in);
      mrt = 1'b0;
      mft = 1'b0;
      if (rst) begin
         t = 0;
         prime = 1'b1;
         mflags = 6'b0;
      end else if (prime) begin
         mflags = raw;
         prime = 1'b0;
      end else if (bus.Enable) begin
         t++;
         mrt = (t % CD) == 0;
         mft = (t % (CD * ROWS)) == 0;
         if (mft) mflags = raw;
      end
      e.row   = 3'(mrow());
      e.img   = 1'(mimg());
      e.flags = mflags;
      e.rt    = mrt;
      e.ft    = mft;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // p < 0 means any prescaler phase; img < 0 means any image
   task automatic run_until(input string name, input int r, input int p, input int img);
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 400) begin
         hit = !prime && (mrow() == r) && (p < 0 || (t % CD) == p) && (img < 0 || mimg() == img);
         if (!hit) begin
            tick();
            n++;
         end
      end
      chk(name, int'(hit), 1);
   endtask

   task automatic set_flags(input logic [5:0] f);
      {bus.Critico_in, bus.Baixo_in, bus.Medio_in, bus.Alto_in,
       bus.Aspersao_in, bus.Gotejamento_in} = f;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("row", int'(bus.Clock_Linhas), int'(e.row));
            chk("img_sel", int'(bus.img_sel), int'(e.img));
            chk("flags", int'({bus.Critico, bus.Baixo, bus.Medio, bus.Alto,
                               bus.Aspersao, bus.Gotejamento}), int'(e.flags));
            chk("row_tick", int'(bus.row_tick), int'(e.rt));
            chk("frame_tick", int'(bus.frame_tick), int'(e.ft));
            if (bus.frame_tick) chk("frame_tick_row0", int'(bus.Clock_Linhas), 0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.Enable = 1'b1;
      set_flags(6'b010000);
      run(3);
      rst = 1'b0;
      run(130);

      run_until("reach_row3", 3, -1, -1);
      set_flags(6'b001000);
      run(40);

      set_flags(6'b100111);
      run(40);

      run_until("reach_row5_p2", 5, 2, -1);
      bus.Enable = 1'b0;
      run(10);
      bus.Enable = 1'b1;
      run(20);

      run_until("reach_img1", 2, 1, 1);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      set_flags(6'b000101);
      run(60);

      for (int i = 0; i < 900; i++) begin
         set_flags(6'($urandom_range(0, 63)));
         bus.Enable = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      bus.Enable = 1'b1;
      run(5);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
